// File: rtl/pipe_cpa_pkg.sv
// Shared constants and stage-control type for the segmented pipelined carry-propagate adder.
package pipe_cpa_pkg;

  localparam int CPA_WIDTH = 64;
  localparam int CPA_SEG_W = 16;

  // Control half of a stage register; the top wraps it with operand/sum slices sized by WIDTH.
  typedef struct packed {
    logic vld;
    logic carry;
    logic sub;
  } cpa_ctl_t;

endpackage

// File: rtl/cpa_seg.sv
// Combinational W-bit ripple-carry segment adder; one instance per pipeline stage.
module cpa_seg
  import pipe_cpa_pkg::*;
#(
  parameter int W = CPA_SEG_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipe_cpa.sv
// Pipelined add/sub: stage k adds segment k, upper operands skew forward, finished sum
// segments ride along so every beat exits whole. One global stall enable, bubbles kept.
module pipe_cpa
  import pipe_cpa_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int SEG_W = CPA_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / SEG_W;

  typedef struct packed {
    cpa_ctl_t         ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  if ((WIDTH % SEG_W) != 0 || NSTG < 1) begin : g_bad_cfg
    $error("pipe_cpa: WIDTH must be a nonzero multiple of SEG_W");
  end

  stg_t                       src [NSTG];
  stg_t                       q   [NSTG];
  logic [NSTG-1:0][SEG_W-1:0] seg_a, seg_b, seg_s;
  logic [NSTG-1:0]            seg_co;
  logic [NSTG:0]              vld_pipe;
  logic                       en;

  // Stage k result: drop segment k's sum into place, forward the carry.
  function automatic stg_t nxt(input stg_t s_in, input logic [SEG_W-1:0] s_seg,
                               input logic co, input int k);
    stg_t r;
    r = s_in;
    r.s[k*SEG_W +: SEG_W] = s_seg;
    r.ctl.carry = co;
    return r;
  endfunction

  assign en          = ~(out_valid & ~out_ready);
  assign in_ready    = en;
  assign vld_pipe[0] = in_valid;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    if (k == 0) begin : g_src
      // Subtract forces carry-in to 1 and ignores cin.
      assign src[0] = '{ctl: '{vld: vld_pipe[0], carry: sub | cin, sub: sub},
                        a: a, b: b, s: '0};
    end else begin : g_src
      assign src[k] = q[k-1];
    end

    assign seg_a[k] = src[k].a[k*SEG_W +: SEG_W];
    assign seg_b[k] = src[k].b[k*SEG_W +: SEG_W] ^ {SEG_W{src[k].ctl.sub}};

    cpa_seg #(.W(SEG_W)) u_seg (
      .a  (seg_a[k]),
      .b  (seg_b[k]),
      .ci (src[k].ctl.carry),
      .s  (seg_s[k]),
      .co (seg_co[k])
    );

    if (k == NSTG-1) begin : g_ff
      // Output stage fully resets so sum/cout/ovf read 0 out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q[k] <= '0;
        else if (en) q[k] <= nxt(src[k], seg_s[k], seg_co[k], k);
      end
    end else begin : g_ff
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q[k].ctl.vld <= 1'b0;
        else if (en) q[k] <= nxt(src[k], seg_s[k], seg_co[k], k);
      end
    end

    assign vld_pipe[k+1] = q[k].ctl.vld;
  end

  assign out_valid = vld_pipe[NSTG];
  assign sum       = q[NSTG-1].s;
  assign cout      = q[NSTG-1].ctl.carry;
  // Overflow from the effective addend's sign (b inverted when subtracting).
  assign ovf       = (q[NSTG-1].a[WIDTH-1] == (q[NSTG-1].b[WIDTH-1] ^ q[NSTG-1].ctl.sub))
                   & (q[NSTG-1].s[WIDTH-1] != q[NSTG-1].a[WIDTH-1]);

endmodule

// File: tb/tb_pipe_cpa.sv
// Scoreboard bench for pipe_cpa: expected results queued on accept, compared on output handshake.
module tb_pipe_cpa;

  localparam int W    = 64;
  localparam int NSTG = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic rnd_rdy  = 1'b0;
  logic hold_rdy = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q [$];

  pipe_cpa #(.WIDTH(W), .SEG_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    logic [W-1:0] be;
    logic [W:0]   f;
    exp_t         r;
    be    = ts ? ~tb_ : tb_;
    f     = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
    r.sum  = f[W-1:0];
    r.cout = f[W];
    r.ovf  = (ta[W-1] == be[W-1]) && (f[W-1] != ta[W-1]);
    return r;
  endfunction

  // Monitor: compare on output handshake, then record newly accepted beats.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input logic ts);
    int n;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic latency(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk(tag, n, NSTG);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed: full carry ripple, signed overflow, subtract with/without borrow
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    latency("lat_ripple");
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    send(64'd5, 64'd7, 1'b0, 1'b1);
    send(64'd7, 64'd5, 1'b1, 1'b1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    drain();

    // Stall: output held stable and in_ready low while blocked
    hold_rdy = 1'b0;
    @(posedge clk);
    #2;
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("stall_reach", out_valid, 1);
      repeat (3) @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      if (exp_q.size() != 0) begin
        chk("stall_sum", sum, exp_q[0].sum);
        chk("stall_cout", cout, exp_q[0].cout);
      end else chk("stall_queue", 0, 1);
    end
    hold_rdy = 1'b1;
    drain();

    // Random back-to-back with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 10; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    drain();
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three beats in flight
    send(64'h1, 64'h2, 1'b0, 1'b0);
    send(64'h3, 64'h4, 1'b0, 1'b0);
    send(64'h5, 64'h6, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    latency("lat_after_rst");
    drain();
    repeat (6) @(negedge clk);
    chk("idle_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
